// File: rtl/key_input_ctrl_pkg.sv
// Shared constants for the reaction-time tester input front end:
// machine_state codes, player encoding, turn limit and debounce FSM states.
package key_input_ctrl_pkg;

  localparam logic [2:0] StateIdle    = 3'd0;
  localparam logic [2:0] StateStart   = 3'd3;
  localparam logic [2:0] StateStorage = 3'd4;
  localparam logic [2:0] StateAverage = 3'd6;

  localparam logic PlayerA = 1'b1;
  localparam logic PlayerB = 1'b0;

  localparam logic [2:0] TurnMax = 3'd7;

  typedef enum logic [1:0] {
    DbReleased,
    DbPressWait,
    DbPressed,
    DbReleaseWait
  } db_state_e;

endpackage

// File: rtl/key_input_ctrl_if.sv
// Signal bundle between the main FSM / buttons (master) and key_input_ctrl (slave).
interface key_input_ctrl_if;
  logic       btn_react_n;
  logic       btn_switch_n;
  logic [2:0] machine_state;
  logic       react_pulse;
  logic       cur_player;
  logic [2:0] test_turn_A;
  logic [2:0] test_turn_B;

  modport master (
    output btn_react_n,
    output btn_switch_n,
    output machine_state,
    input  react_pulse,
    input  cur_player,
    input  test_turn_A,
    input  test_turn_B
  );

  modport slave (
    input  btn_react_n,
    input  btn_switch_n,
    input  machine_state,
    output react_pulse,
    output cur_player,
    output test_turn_A,
    output test_turn_B
  );
endinterface

// File: rtl/key_debounce.sv
// One button: 2-flop synchroniser preset to released, then a 4-state debounce FSM
// that emits a single-cycle registered strobe on entry to PRESSED.
module key_debounce
  import key_input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             press_q, press_d;
  logic             btn_s;

  assign btn_s   = sync_q[1];
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    sync_d  = {sync_q[0], btn_n_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    unique case (state_q)
      DbReleased: begin
        if (!btn_s) begin
          state_d = DbPressWait;
          cnt_d   = '0;
        end
      end
      DbPressWait: begin
        if (btn_s) begin
          state_d = DbReleased;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CntLast) begin
            state_d = DbPressed;
            press_d = 1'b1;
          end
        end
      end
      DbPressed: begin
        if (btn_s) begin
          state_d = DbReleaseWait;
          cnt_d   = '0;
        end
      end
      DbReleaseWait: begin
        // A bounce back to pressed resumes the held press without a new strobe.
        if (!btn_s) begin
          state_d = DbPressed;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CntLast) begin
            state_d = DbReleased;
          end
        end
      end
      default: state_d = DbReleased;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= DbReleased;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/key_input_ctrl.sv
// Input front end: debounces react/switch buttons, emits react_pulse and keeps
// the current player plus per-player saturating test-turn counters.
module key_input_ctrl
  import key_input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input logic             clk,
  input logic             rst,
  key_input_ctrl_if.slave bus
);

  logic       react_strobe, switch_strobe;
  logic       react_pulse_q, react_pulse_d;
  logic       cur_player_q, cur_player_d;
  logic [2:0] turn_a_q, turn_a_d;
  logic [2:0] turn_b_q, turn_b_d;
  logic [2:0] prev_state_q, prev_state_d;
  logic       storage_entry, average_clear;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_react (
    .clk    (clk),
    .rst    (rst),
    .btn_n_i(bus.btn_react_n),
    .press_o(react_strobe)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_switch (
    .clk    (clk),
    .rst    (rst),
    .btn_n_i(bus.btn_switch_n),
    .press_o(switch_strobe)
  );

  assign storage_entry = (bus.machine_state == StateStorage) && (prev_state_q != StateStorage);
  assign average_clear = react_strobe && (bus.machine_state == StateAverage);

  always_comb begin
    react_pulse_d = react_strobe;
    prev_state_d  = bus.machine_state;
    cur_player_d  = cur_player_q;
    turn_a_d      = turn_a_q;
    turn_b_d      = turn_b_q;

    // Switch presses outside IDLE are dropped, not deferred.
    if (switch_strobe && (bus.machine_state == StateIdle)) begin
      cur_player_d = ~cur_player_q;
    end

    if (storage_entry) begin
      if (cur_player_q == PlayerA) begin
        if (turn_a_q != TurnMax) turn_a_d = turn_a_q + 3'd1;
      end else begin
        if (turn_b_q != TurnMax) turn_b_d = turn_b_q + 3'd1;
      end
    end else if (average_clear) begin
      if (cur_player_q == PlayerA) turn_a_d = '0;
      else                         turn_b_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      react_pulse_q <= 1'b0;
      cur_player_q  <= PlayerA;
      turn_a_q      <= '0;
      turn_b_q      <= '0;
      prev_state_q  <= StateIdle;
    end else begin
      react_pulse_q <= react_pulse_d;
      cur_player_q  <= cur_player_d;
      turn_a_q      <= turn_a_d;
      turn_b_q      <= turn_b_d;
      prev_state_q  <= prev_state_d;
    end
  end

  assign bus.react_pulse = react_pulse_q;
  assign bus.cur_player  = cur_player_q;
  assign bus.test_turn_A = turn_a_q;
  assign bus.test_turn_B = turn_b_q;

endmodule
